// File: rtl/fft8_pkg.sv
// Shared definitions for the iterative 8-point FFT sequencer:
// state encoding, data/twiddle widths, twiddle constants and the
// 3-bit bit-reversal helper used for input addressing.
package fft8_pkg;

    localparam int DW   = 9;          // sample width, real and imag each
    localparam int FRAC = 8;          // twiddle fractional bits
    localparam int TWW  = FRAC + 2;   // twiddle constant width (signed)

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_COMP   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    // W^1 = (+0.707, -0.707), W^3 = (-0.707, -0.707) in Q.FRAC (181/256)
    localparam logic signed [TWW-1:0] W1R =  10'sd181;
    localparam logic signed [TWW-1:0] W1I = -10'sd181;
    localparam logic signed [TWW-1:0] W3R = -10'sd181;
    localparam logic signed [TWW-1:0] W3I = -10'sd181;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft8_bfly_unit.sv
// Combinational radix-2 DIT complex butterfly:
//   t = W^e * B,  A' = A + t,  B' = A - t.
// W^0 and W^2 are exact pass / swap-negate paths; W^1 and W^3 use four
// products, each arithmetic-shifted right by FRAC before being summed.
// Optional macro FFT8_SAT_EN: saturate every add/sub to the DW-bit range;
// without it results wrap modulo 2^DW.
module fft8_bfly_unit
    import fft8_pkg::*;
#(
    parameter int DW   = 9,
    parameter int FRAC = 8
) (
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [1:0]    e,
    output logic [DW-1:0] top_re,
    output logic [DW-1:0] top_im,
    output logic [DW-1:0] bot_re,
    output logic [DW-1:0] bot_im
);

    localparam int PW = DW + TWW;   // full product width
    localparam int SW = DW + 3;     // headroom for A +/- t before fitting

`ifdef FFT8_SAT_EN
    localparam logic signed [SW-1:0] SAT_HI = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    // Bring a wide intermediate back into DW bits (saturate or wrap)
    function automatic logic [DW-1:0] fit(input logic signed [SW-1:0] v);
`ifdef FFT8_SAT_EN
        if (v > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end else begin
            return v[DW-1:0];
        end
`else
        return v[DW-1:0];
`endif
    endfunction

    logic signed [TWW-1:0] wr, wi;
    logic signed [PW-1:0]  wr_x, wi_x, br_x, bi_x;
    logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0]  s_rr, s_ii, s_ri, s_ir;
    logic signed [SW-1:0]  ar_s, ai_s, br_s, bi_s;
    logic signed [SW-1:0]  t_re, t_im;
    logic signed [SW-1:0]  sum_re, sum_im, dif_re, dif_im;

    // Twiddle product t = W^e * B followed by the add/sub pair
    always_comb begin
        wr = W1R;
        wi = W1I;
        if (e == 2'd3) begin
            wr = W3R;
            wi = W3I;
        end

        ar_s = SW'($signed(a_re));
        ai_s = SW'($signed(a_im));
        br_s = SW'($signed(b_re));
        bi_s = SW'($signed(b_im));

        wr_x = PW'(wr);
        wi_x = PW'(wi);
        br_x = PW'($signed(b_re));
        bi_x = PW'($signed(b_im));

        p_rr = wr_x * br_x;
        p_ii = wi_x * bi_x;
        p_ri = wr_x * bi_x;
        p_ir = wi_x * br_x;

        s_rr = SW'(p_rr >>> FRAC);
        s_ii = SW'(p_ii >>> FRAC);
        s_ri = SW'(p_ri >>> FRAC);
        s_ir = SW'(p_ir >>> FRAC);

        case (e)
            2'd0: begin
                t_re = br_s;
                t_im = bi_s;
            end
            2'd2: begin
                // (0,-1) * (br + j bi) = bi - j br
                t_re = bi_s;
                t_im = -br_s;
            end
            default: begin
                t_re = s_rr - s_ii;
                t_im = s_ri + s_ir;
            end
        endcase

        sum_re = ar_s + t_re;
        sum_im = ai_s + t_im;
        dif_re = ar_s - t_re;
        dif_im = ai_s - t_im;

        top_re = fit(sum_re);
        top_im = fit(sum_im);
        bot_re = fit(dif_re);
        bot_im = fit(dif_im);
    end

endmodule

// File: rtl/fft8_iter_ctrl.sv
// Iterative 8-point radix-2 DIT FFT sequencer sharing one butterfly.
// LOAD: accept 8 samples, stored bit-reversed. COMP: 12 in-place
// butterflies, one per cycle. UNLOAD: stream X0..X7 in natural order.
// Optional macro FFT8_SAT_EN (handled in fft8_bfly_unit): saturating
// butterfly arithmetic instead of wrap-around; timing is unchanged.
module fft8_iter_ctrl
    import fft8_pkg::*;
#(
    parameter int DW   = 9,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    state_t      state_reg, state_next;
    logic [2:0]  load_cnt_reg;
    logic [3:0]  comp_cnt_reg;
    logic [2:0]  out_idx_reg;

    logic [DW-1:0] ram_re_reg  [8];
    logic [DW-1:0] ram_im_reg  [8];
    logic [DW-1:0] ram_re_next [8];
    logic [DW-1:0] ram_im_next [8];

    logic        load_fire, comp_active, comp_last, unload_fire;
    logic [2:0]  load_addr, top_addr, bot_addr;
    logic [1:0]  tw_exp;
    logic [DW-1:0] bf_top_re, bf_top_im, bf_bot_re, bf_bot_im;

    // Next-state and handshake outputs
    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        load_fire   = 1'b0;
        comp_active = 1'b0;
        comp_last   = 1'b0;
        unload_fire = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                in_ready  = 1'b1;
                load_fire = in_valid;
                if (in_valid && (load_cnt_reg == 3'd7)) begin
                    state_next = ST_COMP;
                end
            end
            ST_COMP: begin
                busy        = 1'b1;
                comp_active = 1'b1;
                comp_last   = (comp_cnt_reg == 4'd11);
                if (comp_last) begin
                    state_next = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                busy        = 1'b1;
                out_valid   = 1'b1;
                unload_fire = out_ready;
                if (out_ready && (out_idx_reg == 3'd7)) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_LOAD;
            load_cnt_reg <= 3'd0;
            comp_cnt_reg <= 4'd0;
            out_idx_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            if (load_fire) begin
                load_cnt_reg <= load_cnt_reg + 3'd1;
            end
            if (comp_active) begin
                comp_cnt_reg <= comp_last ? 4'd0 : comp_cnt_reg + 4'd1;
            end
            if (unload_fire) begin
                out_idx_reg <= out_idx_reg + 3'd1;
            end
        end
    end

    // Butterfly address and twiddle generation from c = {s, k}
    always_comb begin
        load_addr = bitrev3(load_cnt_reg);
        case (comp_cnt_reg[3:2])
            2'd0: begin
                top_addr = {comp_cnt_reg[1:0], 1'b0};
                bot_addr = {comp_cnt_reg[1:0], 1'b1};
                tw_exp   = 2'd0;
            end
            2'd1: begin
                top_addr = {comp_cnt_reg[1], 1'b0, comp_cnt_reg[0]};
                bot_addr = {comp_cnt_reg[1], 1'b1, comp_cnt_reg[0]};
                tw_exp   = {comp_cnt_reg[0], 1'b0};
            end
            default: begin
                top_addr = {1'b0, comp_cnt_reg[1:0]};
                bot_addr = {1'b1, comp_cnt_reg[1:0]};
                tw_exp   = comp_cnt_reg[1:0];
            end
        endcase
    end

    fft8_bfly_unit #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_bfly (
        .a_re   (ram_re_reg[top_addr]),
        .a_im   (ram_im_reg[top_addr]),
        .b_re   (ram_re_reg[bot_addr]),
        .b_im   (ram_im_reg[bot_addr]),
        .e      (tw_exp),
        .top_re (bf_top_re),
        .top_im (bf_top_im),
        .bot_re (bf_bot_re),
        .bot_im (bf_bot_im)
    );

    // Per-entry write selection: load beat, butterfly top or bottom
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ram_next
            logic wr_load, wr_top, wr_bot;
            assign wr_load = load_fire && (load_addr == 3'(gi));
            assign wr_top  = comp_active && (top_addr == 3'(gi));
            assign wr_bot  = comp_active && (bot_addr == 3'(gi));
            assign ram_re_next[gi] = wr_load ? in_re :
                                     wr_top  ? bf_top_re :
                                     wr_bot  ? bf_bot_re : ram_re_reg[gi];
            assign ram_im_next[gi] = wr_load ? in_im :
                                     wr_top  ? bf_top_im :
                                     wr_bot  ? bf_bot_im : ram_im_reg[gi];
        end
    endgenerate

    // Sample RAM, cleared by reset so no frame residue survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ram_re_reg[i] <= '0;
                ram_im_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                ram_re_reg[i] <= ram_re_next[i];
                ram_im_reg[i] <= ram_im_next[i];
            end
        end
    end

    assign out_idx  = out_idx_reg;
    assign out_last = out_valid && (out_idx_reg == 3'd7);
    assign out_re   = ram_re_reg[out_idx_reg];
    assign out_im   = ram_im_reg[out_idx_reg];

endmodule
